mem_burst_sched: RTL and testbench

Round-robin burst scheduler that shares the single-ported scratchpad write/read path between `PORT_COUNT` processor ports. It grants one requester at a time and holds that grant for a whole multi-beat burst. During the burst it sequences the incrementing beat addresses and the read/write enables toward the memory. It also drives the select index for the port data/address muxes, and returns per-port beat, done and read-valid strobes.

---
 rtl/mem_burst_sched_if.sv | 35 +++
 rtl/mem_burst_sched.sv | 115 +++++++++++
 tb/tb_mem_burst_sched.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_burst_sched_if.sv
// Request / memory-side bundle of the round-robin burst scheduler.
// master = requesters and memory side, slave = scheduler.
interface mem_burst_sched_if #(
   parameter int PORT_COUNT = 4,
   parameter int ADDR_SIZE  = 24,
   parameter int BLEN_W     = 3
);
   localparam int SEL_W = $clog2(PORT_COUNT);

   logic [PORT_COUNT-1:0] i_req;
   logic [PORT_COUNT-1:0] i_we;
   logic [ADDR_SIZE-1:0]  i_addr [PORT_COUNT];
   logic [BLEN_W-1:0]     i_blen [PORT_COUNT];

   logic [PORT_COUNT-1:0] o_grant;
   logic [SEL_W-1:0]      o_sel;
   logic [ADDR_SIZE-1:0]  o_mem_addr;
   logic                  o_mem_wr_en;
   logic                  o_mem_rd_en;
   logic [PORT_COUNT-1:0] o_beat;
   logic [PORT_COUNT-1:0] o_done;
   logic [PORT_COUNT-1:0] o_rd_valid;

   modport master (
      output i_req, i_we, i_addr, i_blen,
      input  o_grant, o_sel, o_mem_addr, o_mem_wr_en,
      input  o_mem_rd_en, o_beat, o_done, o_rd_valid
   );

   modport slave (
      input  i_req, i_we, i_addr, i_blen,
      output o_grant, o_sel, o_mem_addr, o_mem_wr_en,
      output o_mem_rd_en, o_beat, o_done, o_rd_valid
   );
endinterface

// File: rtl/mem_burst_sched.sv
// Round-robin burst scheduler: one port owns the scratchpad for a whole
// burst, beats are sequenced from latched base/length.
module mem_burst_sched #(
   parameter int PORT_COUNT = 4,
   parameter int ADDR_SIZE  = 24,
   parameter int BLEN_W     = 3
) (
   input logic              i_clk,
   input logic              i_rstn,
   mem_burst_sched_if.slave bus
);
   localparam int SEL_W = $clog2(PORT_COUNT);

   typedef enum logic {IDLE, BURST} state_e;

   state_e                state_q, state_d;
   logic [SEL_W-1:0]      port_q, port_d;
   logic [SEL_W-1:0]      rr_q, rr_d;
   logic                  we_q, we_d;
   logic [ADDR_SIZE-1:0]  base_q, base_d;
   logic [BLEN_W-1:0]     blen_q, blen_d;
   logic [BLEN_W-1:0]     cnt_q, cnt_d;
   logic [PORT_COUNT-1:0] rdv_q, rdv_d;

   logic [SEL_W-1:0]      win;
   logic                  found;
   logic                  busy;
   logic                  last;
   logic [PORT_COUNT-1:0] port_oh;
   int                    idx;

   // First requester at or after rr_q, wrapping modulo PORT_COUNT.
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < PORT_COUNT; i++) begin
         idx = (int'(rr_q) + i) % PORT_COUNT;
         if (!found && bus.i_req[idx]) begin
            found = 1'b1;
            win   = SEL_W'(idx);
         end
      end
   end

   assign busy    = (state_q == BURST);
   assign last    = busy && (cnt_q == blen_q);
   assign port_oh = busy ? (PORT_COUNT'(1) << port_q) : '0;

   always_comb begin
      state_d = state_q;
      port_d  = port_q;
      rr_d    = rr_q;
      we_d    = we_q;
      base_d  = base_q;
      blen_d  = blen_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d = BURST;
               port_d  = win;
               we_d    = bus.i_we[win];
               base_d  = bus.i_addr[win];
               blen_d  = bus.i_blen[win];
               cnt_d   = '0;
            end
         end
         BURST: begin
            if (last) begin
               state_d = IDLE;
               rr_d    = (port_q == SEL_W'(PORT_COUNT - 1)) ?
                         '0 : port_q + 1'b1;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Read data returns one cycle after the beat that requested it.
   assign rdv_d = (busy && !we_q) ? port_oh : '0;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= IDLE;
         port_q  <= '0;
         rr_q    <= '0;
         we_q    <= 1'b0;
         base_q  <= '0;
         blen_q  <= '0;
         cnt_q   <= '0;
         rdv_q   <= '0;
      end else begin
         state_q <= state_d;
         port_q  <= port_d;
         rr_q    <= rr_d;
         we_q    <= we_d;
         base_q  <= base_d;
         blen_q  <= blen_d;
         cnt_q   <= cnt_d;
         rdv_q   <= rdv_d;
      end
   end

   assign bus.o_grant     = port_oh;
   assign bus.o_beat      = port_oh;
   assign bus.o_done      = last ? port_oh : '0;
   assign bus.o_sel       = busy ? port_q : '0;
   assign bus.o_mem_addr  = busy ? base_q + ADDR_SIZE'(cnt_q) : '0;
   assign bus.o_mem_wr_en = busy && we_q;
   assign bus.o_mem_rd_en = busy && !we_q;
   assign bus.o_rd_valid  = rdv_q;
endmodule

// File: tb/tb_mem_burst_sched.sv
// Bench for mem_burst_sched: transaction-level arbitration model feeds a
// cycle-stamped scoreboard drained by an independent monitor.
module tb_mem_burst_sched;
   localparam int PC = 4;
   localparam int AW = 24;
   localparam int BW = 3;

   typedef struct {
      int          cyc;
      int          port;
      logic [AW-1:0] addr;
      logic        we;
      logic        done;
   } beat_t;

   typedef struct {
      int cyc;
      int port;
   } rdv_t;

   logic clk = 1'b0;
   logic rst_n;

   mem_burst_sched_if #(.PORT_COUNT(PC), .ADDR_SIZE(AW), .BLEN_W(BW)) bus();

   mem_burst_sched #(.PORT_COUNT(PC), .ADDR_SIZE(AW), .BLEN_W(BW)) dut (
      .i_clk  (clk),
      .i_rstn (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int       cyc;
   int       n_tests;
   int       n_fail;
   beat_t    bq[$];
   rdv_t     rq[$];
   int       m_free;
   int       m_rr;
   int       win;
   logic [PC-1:0] keep;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
      end
   endtask

   // Arbitration decision for the current cycle, expanded into stamped beats.
   task automatic model_eval();
      int bl;
      win = -1;
      if (cyc >= m_free && bus.i_req != '0) begin
         for (int i = 0; i < PC; i++) begin
            int p = (m_rr + i) % PC;
            if (win < 0 && bus.i_req[p]) win = p;
         end
         bl = int'(bus.i_blen[win]);
         for (int k = 0; k <= bl; k++) begin
            beat_t b;
            rdv_t  r;
            b.cyc  = cyc + 1 + k;
            b.port = win;
            b.addr = bus.i_addr[win] + AW'(k);
            b.we   = bus.i_we[win];
            b.done = (k == bl);
            bq.push_back(b);
            if (!b.we) begin
               r.cyc  = cyc + 2 + k;
               r.port = win;
               rq.push_back(r);
            end
         end
         m_free = cyc + 2 + bl;
         m_rr   = (win + 1) % PC;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic next_cycle();
      model_eval();
      tick();
      if (win >= 0 && !keep[win]) bus.i_req[win] = 1'b0;
   endtask

   task automatic run(int n);
      repeat (n) next_cycle();
   endtask

   task automatic set_req(int p, logic we, logic [AW-1:0] a, logic [BW-1:0] bl);
      bus.i_req[p]  = 1'b1;
      bus.i_we[p]   = we;
      bus.i_addr[p] = a;
      bus.i_blen[p] = bl;
   endtask

   task automatic do_reset(int hold);
      rst_n = 1'b0;
      bq.delete();
      rq.delete();
      m_rr = 0;
      #1;
      chk("rst_async_ctl", {bus.o_grant, bus.o_sel, bus.o_mem_wr_en,
          bus.o_mem_rd_en, bus.o_beat, bus.o_done, bus.o_rd_valid}, 64'd0);
      chk("rst_async_addr", 64'(bus.o_mem_addr), 64'd0);
      repeat (hold) tick();
      bus.i_req = '0;
      rst_n  = 1'b1;
      m_free = cyc;
   endtask

   always @(negedge clk) begin
      beat_t e;
      rdv_t  r;
      if (!rst_n) begin
         chk("rst_outs", {bus.o_grant, bus.o_sel, bus.o_mem_wr_en,
             bus.o_mem_rd_en, bus.o_beat, bus.o_done, bus.o_rd_valid}, 64'd0);
         chk("rst_addr", 64'(bus.o_mem_addr), 64'd0);
      end else begin
         while (bq.size() > 0 && bq[0].cyc < cyc) begin
            e = bq.pop_front();
            chk("missed_beat", 64'(cyc), 64'(e.cyc));
         end
         if (bq.size() > 0 && bq[0].cyc == cyc) begin
            e = bq.pop_front();
            chk("grant", 64'(bus.o_grant), 64'(1) << e.port);
            chk("sel", 64'(bus.o_sel), 64'(e.port));
            chk("beat", 64'(bus.o_beat), 64'(1) << e.port);
            chk("addr", 64'(bus.o_mem_addr), 64'(e.addr));
            chk("wr_en", 64'(bus.o_mem_wr_en), 64'(e.we));
            chk("rd_en", 64'(bus.o_mem_rd_en), 64'(!e.we));
            chk("done", 64'(bus.o_done), e.done ? (64'(1) << e.port) : 64'd0);
         end else begin
            chk("idle_gbd", {bus.o_grant, bus.o_beat, bus.o_done}, 64'd0);
            chk("idle_en", {bus.o_mem_wr_en, bus.o_mem_rd_en}, 64'd0);
         end
         while (rq.size() > 0 && rq[0].cyc < cyc) begin
            r = rq.pop_front();
            chk("missed_rdv", 64'(cyc), 64'(r.cyc));
         end
         if (rq.size() > 0 && rq[0].cyc == cyc) begin
            r = rq.pop_front();
            chk("rd_valid", 64'(bus.o_rd_valid), 64'(1) << r.port);
         end else begin
            chk("rd_valid_idle", 64'(bus.o_rd_valid), 64'd0);
         end
      end
   end

   initial begin
      logic [AW-1:0] a;
      rst_n   = 1'b1;
      cyc     = 0;
      n_tests = 0;
      n_fail  = 0;
      m_free  = 0;
      m_rr    = 0;
      win     = -1;
      keep    = '0;
      bus.i_req = '0;
      bus.i_we  = '0;
      for (int p = 0; p < PC; p++) begin
         bus.i_addr[p] = '0;
         bus.i_blen[p] = '0;
      end
      #2;
      do_reset(2);

      set_req(2, 1'b0, 24'h000100, 3'd3);
      run(8);

      do_reset(1);
      for (int p = 0; p < PC; p++)
         set_req(p, 1'($urandom), AW'($urandom), 3'd0);
      run(12);

      set_req(1, 1'b1, 24'hFFFFFE, 3'd3);
      run(8);

      do_reset(1);
      set_req(0, 1'b1, 24'h000040, 3'd2);
      set_req(3, 1'b0, 24'h000400, 3'd1);
      keep[0] = 1'b1;
      run(9);
      keep = '0;
      bus.i_req = '0;
      run(6);

      set_req(1, 1'b0, 24'h123450, 3'd7);
      run(4);
      bus.i_addr[1] = 24'hABCDEF;
      bus.i_we[1]   = 1'b1;
      bus.i_blen[1] = 3'd1;
      run(10);

      set_req(3, 1'b0, 24'h000800, 3'd7);
      run(3);
      do_reset(2);
      set_req(3, 1'b0, 24'h000900, 3'd1);
      set_req(0, 1'b1, 24'h000A00, 3'd2);
      run(12);

      for (int t = 0; t < 3000; t++) begin
         for (int p = 0; p < PC; p++) begin
            if (!bus.i_req[p]) begin
               if ($urandom_range(5) == 0) begin
                  a = ($urandom_range(3) == 0) ?
                      24'hFFFFF8 + AW'($urandom_range(7)) : AW'($urandom);
                  set_req(p, 1'($urandom), a, BW'($urandom));
               end else if ($urandom_range(1) == 0) begin
                  bus.i_addr[p] = AW'($urandom);
                  bus.i_we[p]   = 1'($urandom);
                  bus.i_blen[p] = BW'($urandom);
               end
            end else if ($urandom_range(59) == 0) begin
               bus.i_req[p] = 1'b0;
            end
         end
         keep = PC'($urandom) & PC'($urandom);
         next_cycle();
      end

      keep = '0;
      bus.i_req = '0;
      for (int t = 0; t < 100; t++) begin
         if (bq.size() == 0 && rq.size() == 0) break;
         next_cycle();
      end
      run(2);
      chk("drain", 64'(bq.size() + rq.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
